multi_timer: RTL and testbench

Parametrised bank of NUM_CH independent down-counting timer channels behind one memory-mapped register port, with per-channel interrupt lines. Sits on the processor's peripheral side of the system bridge. Generalises the fixed two-instance single-timer arrangement into one block with:
- a configurable channel count and counter width;
- a third interrupt mode (pulse);
- write-1-to-clear status.

---
 rtl/timer_pkg.sv | 33 +++
 rtl/multi_timer_if.sv | 16 +
 rtl/timer_channel.sv | 136 +++++++++++++
 rtl/multi_timer.sv | 81 ++++++++
 tb/tb_multi_timer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants and types for the multi_timer block
// Purpose: register offsets, CTRL/STATUS bit positions, mode encodings and
//          the channel state type used by multi_timer and timer_channel.
// Ports:   none (package).
package timer_pkg;

  // Register select, taken from addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL bit positions (MODE occupies CTRL_MODE +: 2)
  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;

  // STATUS bit positions
  localparam int STAT_PEND = 0;
  localparam int STAT_RUN  = 1;

  // Mode encodings; the reserved code behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;
  localparam logic [1:0] MODE_PULSE   = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  typedef enum logic {
    IDLE,
    CNT
  } ch_state_e;

endpackage

// File: rtl/multi_timer_if.sv
// rtl/multi_timer_if.sv - register port bundle for multi_timer
// Purpose: groups the memory-mapped register port signals.
// Signals: addr (byte address), we (write strobe), wdata (write data),
//          rdata (combinational read data).
// Modports: master drives addr/we/wdata, slave drives rdata.
interface multi_timer_if #(
  parameter int AW = 5
);
  logic [AW-1:0] addr;
  logic          we;
  logic [31:0]   wdata;
  logic [31:0]   rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one down-counting timer channel
// Purpose: holds CTRL/PRESET/COUNT/STATUS for one channel, runs the
//          IDLE/CNT FSM and produces the channel interrupt.
// Ports:   clk, reset (async active-low);
//          ctrl_we/preset_we/status_we: register write strobes for this channel;
//          wdata: write data; ctrl/preset/count/pend/run: register read values;
//          irq: IM & (PEND | expire pulse).
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_we,
  input  logic             preset_we,
  input  logic             status_we,
  input  logic [CNT_W-1:0] wdata,
  output logic [3:0]       ctrl,
  output logic [CNT_W-1:0] preset,
  output logic [CNT_W-1:0] count,
  output logic             pend,
  output logic             run,
  output logic             irq
);

  ch_state_e        state_q, state_d;
  logic             en_q, en_d;
  logic             im_q, im_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_q, pend_d;
  logic             pulse_q, pulse_d;
  logic             expire_set;
  logic [1:0]       eff_mode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      im_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      im_q     <= im_d;
      mode_q   <= mode_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      pulse_q  <= pulse_d;
    end
  end

  assign eff_mode = (mode_q == MODE_RSVD) ? MODE_ONESHOT : mode_q;

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    im_d       = im_q;
    mode_d     = mode_q;
    preset_d   = preset_q;
    count_d    = count_q;
    pend_d     = pend_q;
    pulse_d    = 1'b0;
    expire_set = 1'b0;

    // The FSM acts on the registered CTRL, so a CTRL write is seen one edge later.
    // Reloads use the registered PRESET, so a PRESET write never alters the
    // value loaded on the same edge.
    case (state_q)
      IDLE: begin
        if (en_q) begin
          count_d = preset_q;
          state_d = CNT;
        end
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          // count of 0 or 1 expires, which makes PRESET=0 act like PRESET=1
          case (eff_mode)
            MODE_RELOAD: begin
              count_d    = preset_q;
              expire_set = 1'b1;
            end
            MODE_PULSE: begin
              count_d = preset_q;
              pulse_d = 1'b1;
            end
            default: begin
              count_d    = '0;
              en_d       = 1'b0;
              expire_set = 1'b1;
              state_d    = IDLE;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    if (ctrl_we) begin
      en_d   = wdata[CTRL_EN];
      mode_d = wdata[CTRL_MODE +: 2];
      im_d   = wdata[CTRL_IM];
      pend_d = 1'b0;
    end
    if (preset_we) begin
      preset_d = wdata;
    end
    if (status_we && wdata[STAT_PEND]) begin
      pend_d = 1'b0;
    end
    // expiry outranks any clear arriving on the same edge
    if (expire_set) begin
      pend_d = 1'b1;
    end
  end

  assign ctrl   = {im_q, mode_q, en_q};
  assign preset = preset_q;
  assign count  = count_q;
  assign pend   = pend_q;
  assign run    = (state_q == CNT);
  assign irq    = im_q & (pend_q | pulse_q);

endmodule

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - bank of NUM_CH timer channels behind one register port
// Purpose: address decode, per-channel write steering, read mux and irq_any.
// Ports:   clk, reset (async active-low);
//          bus (slave): addr/we/wdata in, rdata out (combinational);
//          irq: per-channel interrupt; irq_any: OR of irq.
module multi_timer
  import timer_pkg::*;
#(
  parameter  int NUM_CH = 2,
  parameter  int CNT_W  = 32,
  localparam int AW     = $clog2(NUM_CH) + 4
) (
  input  logic              clk,
  input  logic              reset,
  multi_timer_if.slave      bus,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  logic [AW-1:0] addr;
  logic [31:0]   ch_sel;
  logic [1:0]    reg_sel;
  logic [31:0]   rdata;
  logic          unused_bits;

  logic [3:0]       ctrl_rd   [NUM_CH];
  logic [CNT_W-1:0] preset_rd [NUM_CH];
  logic [CNT_W-1:0] count_rd  [NUM_CH];
  logic             pend_rd   [NUM_CH];
  logic             run_rd    [NUM_CH];

  assign addr    = bus.addr;
  // Channel index may reach beyond NUM_CH; such indices match no channel.
  assign ch_sel  = 32'(addr >> 4);
  assign reg_sel = addr[3:2];
  assign unused_bits = ^{bus.wdata, addr[1:0]};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = bus.we && (ch_sel == 32'(i));

    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .ctrl_we   (hit && (reg_sel == REG_CTRL)),
      .preset_we (hit && (reg_sel == REG_PRESET)),
      .status_we (hit && (reg_sel == REG_STATUS)),
      .wdata     (bus.wdata[CNT_W-1:0]),
      .ctrl      (ctrl_rd[i]),
      .preset    (preset_rd[i]),
      .count     (count_rd[i]),
      .pend      (pend_rd[i]),
      .run       (run_rd[i]),
      .irq       (irq[i])
    );
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 32'(i)) begin
        case (reg_sel)
          REG_CTRL:   rdata = {28'd0, ctrl_rd[i]};
          REG_PRESET: rdata = 32'(preset_rd[i]);
          REG_COUNT:  rdata = 32'(count_rd[i]);
          REG_STATUS: begin
            rdata[STAT_PEND] = pend_rd[i];
            rdata[STAT_RUN]  = run_rd[i];
          end
          default: rdata = '0;
        endcase
      end
    end
  end

  assign bus.rdata = rdata;
  assign irq_any   = |irq;

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - self-checking bench for multi_timer
module tb_multi_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] irq;
  logic       irq_any;
  int         n_assert = 0;
  int         n_fail   = 0;
  logic [31:0] v;

  multi_timer_if #(.AW(6)) bus ();

  multi_timer #(
    .NUM_CH(3),
    .CNT_W (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .irq    (irq),
    .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] A(input int ch, input int r);
    return 6'((ch << 4) | (r << 2));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // All stimulus runs from just after a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    @(negedge clk);
    bus.we    = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(tag, bus.rdata, exp);
  endtask

  initial begin
    bus.addr  = '0;
    bus.we    = 1'b0;
    bus.wdata = '0;
    reset     = 1'b0;
    step(2);

    // reset state
    chk("rst_irq", 32'(irq), 0);
    chk("rst_irq_any", 32'(irq_any), 0);
    chk_rd("rst_ctrl0", A(0,0), 0);
    chk_rd("rst_count0", A(0,2), 0);
    reset = 1'b1;
    step(1);

    // reset mid-count
    wr(A(0,1), 10);
    wr(A(0,0), 'hB);
    step(4);
    chk_rd("pre_rst_count", A(0,2), 7);
    reset = 1'b0;
    #1;
    chk("midrst_irq", 32'(irq), 0);
    chk_rd("midrst_count", A(0,2), 0);
    chk_rd("midrst_ctrl", A(0,0), 0);
    step(1);
    reset = 1'b1;
    step(5);
    chk_rd("postrst_count", A(0,2), 0);
    chk_rd("postrst_status", A(0,3), 0);
    chk("postrst_irq", 32'(irq), 0);

    // one-shot
    wr(A(0,1), 5);
    wr(A(0,0), 'h9);
    step(5);
    chk("os_irq_early", 32'(irq[0]), 0);
    chk_rd("os_count_1", A(0,2), 1);
    step(1);
    chk("os_irq", 32'(irq[0]), 1);
    chk("os_irq_any", 32'(irq_any), 1);
    chk_rd("os_ctrl", A(0,0), 'h8);
    chk_rd("os_count_0", A(0,2), 0);
    wr(A(0,3), 1);
    chk("os_w1c_irq", 32'(irq[0]), 0);

    // auto-reload with PRESET change mid-period
    wr(A(1,1), 3);
    wr(A(1,0), 'hB);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk_rd($sformatf("ar_count_k%0d", k), A(1,2), (k == 4) ? 3 : 4 - k);
      chk($sformatf("ar_irq_k%0d", k), 32'(irq[1]), (k == 4) ? 1 : 0);
    end
    wr(A(1,3), 1);
    chk_rd("ar_count_e5", A(1,2), 2);
    chk("ar_irq_e5", 32'(irq[1]), 0);
    step(1);
    chk_rd("ar_count_e6", A(1,2), 1);
    wr(A(1,1), 7);
    chk_rd("ar_count_e7", A(1,2), 3);
    chk("ar_irq_e7", 32'(irq[1]), 1);
    chk_rd("ar_preset", A(1,1), 7);
    step(1);
    chk_rd("ar_count_e8", A(1,2), 2);
    step(1);
    chk_rd("ar_count_e9", A(1,2), 1);
    step(1);
    chk_rd("ar_count_e10", A(1,2), 7);
    wr(A(1,0), 0);

    // pulse mode
    wr(A(2,1), 4);
    wr(A(2,0), 'hD);
    for (int k = 1; k <= 13; k++) begin
      logic e;
      step(1);
      e = (k >= 5) && ((k - 5) % 4 == 0);
      chk($sformatf("pl_irq_k%0d", k), 32'(irq[2]), 32'(e));
      chk($sformatf("pl_any_k%0d", k), 32'(irq_any), 32'(e));
    end
    chk_rd("pl_status", A(2,3), 'h2);
    wr(A(2,0), 'h5);
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk($sformatf("pl_noim_k%0d", k), 32'(irq[2]), 0);
    end
    chk_rd("pl_noim_count", A(2,2), 3);
    chk_rd("pl_noim_status", A(2,3), 'h2);
    wr(A(2,0), 0);

    // W1C on the expiry edge: set wins
    wr(A(0,1), 3);
    wr(A(0,0), 'hB);
    step(3);
    wr(A(0,3), 1);
    chk_rd("col_status", A(0,3), 'h3);
    chk("col_irq", 32'(irq[0]), 1);
    wr(A(0,0), 0);
    chk("col_ctrl_clr_irq", 32'(irq[0]), 0);

    // EN cleared mid-count holds COUNT
    wr(A(0,1), 10);
    wr(A(0,0), 1);
    step(4);
    chk_rd("en_count7", A(0,2), 7);
    wr(A(0,0), 0);
    chk_rd("en_count6", A(0,2), 6);
    step(3);
    chk_rd("en_hold6", A(0,2), 6);
    chk_rd("en_status", A(0,3), 0);
    wr(A(0,0), 1);
    step(1);
    chk_rd("en_reload", A(0,2), 10);
    wr(A(0,0), 0);

    // out-of-range channel and preset width
    wr(A(3,0), 'hF);
    wr(A(3,1), 'hFF);
    chk_rd("ch3_ctrl", A(3,0), 0);
    chk_rd("ch3_preset", A(3,1), 0);
    chk_rd("ch3_alias_ctrl0", A(0,0), 0);
    chk("ch3_irq", 32'(irq), 0);
    wr(A(0,1), 'hFFFF);
    chk_rd("preset_ffff", A(0,1), 'h0000FFFF);
    wr(A(0,1), 'hABCD1234);
    chk_rd("preset_trunc", A(0,1), 'h1234);

    // PRESET=0 and irq_any
    wr(A(2,1), 0);
    wr(A(2,0), 'h9);
    step(1);
    chk("p0_irq_e1", 32'(irq), 0);
    step(1);
    chk("p0_irq_e2", 32'(irq), 'h4);
    chk("p0_any", 32'(irq_any), 1);
    wr(A(2,3), 1);
    chk("p0_any_clr", 32'(irq_any), 0);
    wr(A(1,1), 0);
    wr(A(1,0), 'h9);
    step(2);
    chk("any_ch1_irq", 32'(irq), 'h2);
    chk("any_ch1", 32'(irq_any), 1);
    wr(A(1,0), 0);

    // randomized trials against an arithmetic model
    for (int t = 0; t < 24; t++) begin
      int ch, p, m, k, pe, j, exp_cnt;
      logic exp_pend, exp_en;
      ch = int'($urandom_range(2));
      p  = int'($urandom_range(12));
      m  = int'($urandom_range(2));
      if (m == 2) m = 3;
      k  = int'($urandom_range(30, 1));
      wr(A(ch,0), 0);
      wr(A(ch,1), 32'(p));
      wr(A(ch,0), 32'(8 | (m << 1) | 1));
      step(k);
      pe = (p == 0) ? 1 : p;
      j  = k - 1;
      exp_pend = (k >= pe + 1);
      if (m == 1) begin
        exp_cnt = (p == 0) ? 0 : p - (j % p);
        exp_en  = 1'b1;
      end else begin
        exp_cnt = (j < pe) ? p - j : 0;
        exp_en  = (k <= pe);
      end
      chk_rd($sformatf("rnd%0d_ch%0d_p%0d_m%0d_k%0d_count", t, ch, p, m, k), A(ch,2), 32'(exp_cnt));
      chk($sformatf("rnd%0d_irq", t), 32'(irq[ch]), 32'(exp_pend));
      chk_rd($sformatf("rnd%0d_ctrl", t), A(ch,0), 32'(8 | (m << 1) | int'(exp_en)));
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
